seq_mem_writer: RTL and testbench
=================================

SEQ_MEM_WRITER -- requirements
Module: seq_mem_writer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter DEPTH, default 100, SHALL set the number of memory words, addressed 0..DEPTH-1.
REQ-003 Parameter CNT_W, default 8, SHALL set the wr_cnt width; CNT_W SHALL hold the value DEPTH.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a single-cycle request to begin or restart a fill at address 0.
REQ-007 in_valid  input  1  SHALL indicate that in_data holds a word offered for writing.
REQ-008 in_data  input  WIDTH  SHALL be the write data word.
REQ-009 in_ready  output  1  SHALL indicate that the block accepts in_data this cycle.
REQ-010 wr_cnt  output  CNT_W  SHALL be the number of words written in the current fill, 0..DEPTH.
REQ-011 done  output  1  SHALL be high while the last fill has completed with DEPTH words.
REQ-012 rd_addr  input  7  SHALL be the read address for the readback port.
REQ-013 rd_data  output  WIDTH  SHALL be the registered readback word.

Function
REQ-014 The block SHALL contain a DEPTH x WIDTH memory with no reset of its contents.
REQ-015 The FSM SHALL have the states IDLE, WRITE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL move the FSM to WRITE on the next edge, clear wr_ptr and wr_cnt to 0, and clear done.
REQ-017 in_ready SHALL be combinational and equal to (state==WRITE) and not start.
REQ-018 A transfer SHALL occur when in_valid and in_ready are both 1; it SHALL write in_data to mem[wr_ptr], increment wr_ptr and increment wr_cnt on that edge.
REQ-019 in_valid=1 with in_ready=0 SHALL write nothing and change no state; the source holds its word.
REQ-020 A transfer at wr_ptr=DEPTH-1 SHALL wrap wr_ptr to 0, set wr_cnt=DEPTH, set done=1 and move the FSM to DONE on the same edge.
REQ-021 start=1 while in WRITE SHALL abort the fill: no write that cycle, wr_ptr=0 and wr_cnt=0 on the next edge, and the FSM stays in WRITE.
REQ-022 In DONE, in_ready SHALL be 0 and wr_cnt and done SHALL hold until the next start.
REQ-023 rd_data SHALL equal mem[rd_addr] one clock after rd_addr is presented, in every state.
REQ-024 A read and a write to the same address in the same cycle SHALL return the old contents.
REQ-025 rd_addr >= DEPTH SHALL return 0 on rd_data.
REQ-026 wr_ptr SHALL never exceed DEPTH-1.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force: state=IDLE, wr_ptr=0, wr_cnt=0, done=0, rd_data=0, and in_ready=0.
REQ-028 Reset asserted mid-fill SHALL discard the fill progress; memory contents written before reset SHALL remain unchanged.
REQ-029 The first edge after rst_n deasserts SHALL act normally; a start on that edge SHALL be honoured.

Structure
REQ-030 A shared package seq_mem_pkg SHALL hold the state enumeration (IDLE/WRITE/DONE) and the constants DEPTH_DEF=100 and WIDTH_DEF=32.
REQ-031 The memory array and its registered read port SHALL be one sub-module, seq_mem_ram (write enable, write address, write data, read address, read data); the FSM and counters SHALL stay in seq_mem_writer.

Verification
REQ-032 Full fill: reset, start, then in_valid held high with data 0x1000+i for 100 cycles -> done=1 after the 100th transfer, wr_cnt=100, in_ready=0; read addresses 0, 50 and 99 -> 0x1000, 0x1032 and 0x1063 one cycle later.
REQ-033 Backpressure and gaps: in_valid toggled 1,0,1,0 over a fill -> exactly 100 writes, wr_cnt increments only on transfer cycles, done at the 100th transfer.
REQ-034 Abort: start pulsed after 40 transfers -> wr_cnt=0 on the next edge and in_ready=0 during the start cycle; the next word lands at address 0, and addresses 1..39 keep their old values until overwritten.
REQ-035 Reset mid-fill: rst_n low after 60 transfers -> wr_cnt=0, done=0, and IDLE with in_ready=0 immediately; readback of address 10 after reset returns the previously written value.
REQ-036 Read-during-write: rd_addr=5 while word 0xDEADBEEF is written to address 5 -> the old value is returned that cycle and 0xDEADBEEF on the following read.
REQ-037 Refill from DONE: start in DONE -> WRITE on the next edge, done=0, and the new data overwrites from address 0.

Source files
------------

// File: rtl/seq_mem_pkg.sv
// Shared types and defaults for the sequential memory writer.
// Holds the FSM state encoding and the default geometry.
package seq_mem_pkg;

  localparam int DEPTH_DEF = 100;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mem_ram.sv
// DEPTH x WIDTH storage with one write port and a registered read port.
// Reads see the pre-write contents on a same-address collision.
module seq_mem_ram
  import seq_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int RAW   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RAW-1:0]   i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  localparam logic [RAW:0] LIM = (RAW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             w_hit;

  assign w_hit = ({1'b0, i_raddr} < LIM);

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range addresses read as zero rather than aliasing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_hit) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/seq_mem_writer.sv
// Fills a DEPTH-word memory from a valid/ready stream, starting at 0.
// A start pulse begins or restarts the fill; the memory is readable always.
module seq_mem_writer
  import seq_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             done,
  input  logic [6:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_e           r_state;
  state_e           w_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    w_wr_ptr;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] w_wr_cnt;
  logic             r_done;
  logic             w_done;
  logic             w_ready;
  logic             w_xfer;

  assign w_ready = (r_state == WRITE) && !start;
  assign w_xfer  = in_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_wr_cnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_wr_ptr <= w_wr_ptr;
      r_wr_cnt <= w_wr_cnt;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_wr_ptr = r_wr_ptr;
    w_wr_cnt = r_wr_cnt;
    w_done   = r_done;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state  = WRITE;
          w_wr_ptr = '0;
          w_wr_cnt = '0;
          w_done   = 1'b0;
        end
      end
      WRITE: begin
        if (start) begin
          w_wr_ptr = '0;
          w_wr_cnt = '0;
        end else if (w_xfer) begin
          if (r_wr_ptr == PTR_LAST) begin
            w_state  = DONE;
            w_wr_ptr = '0;
            w_wr_cnt = CNT_FULL;
            w_done   = 1'b1;
          end else begin
            w_wr_ptr = r_wr_ptr + AW'(1);
            w_wr_cnt = r_wr_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  seq_mem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .RAW   (7)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_xfer),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign in_ready = w_ready;
  assign wr_cnt   = r_wr_cnt;
  assign done     = r_done;

endmodule

// File: tb/tb_seq_mem_writer.sv
// Directed bench for seq_mem_writer: fill, gaps, abort, collision, reset.
// Expected values are hand-derived from the stimulus pattern.
module tb_seq_mem_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [7:0]  wr_cnt;
  logic        done;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;

  int n_chk;
  int n_err;
  int exp_cnt;

  seq_mem_writer #(
    .WIDTH (32),
    .DEPTH (100),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_cnt   (wr_cnt),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    rd_addr = 7'(a);
    step();
    check(tag, rd_data, exp);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_addr  = '0;
    #2;
    check("rst_cnt",   32'(wr_cnt),   32'd0);
    check("rst_done",  32'(done),     32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_rdata", rd_data,       32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_ready", 32'(in_ready), 32'd0);

    // Full fill
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("fill_ready", 32'(in_ready), 32'd1);
    check("fill_cnt0",  32'(wr_cnt),   32'd0);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + 32'(i);
      step();
      if (i == 98) check("fill_notdone", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    check("fill_done",  32'(done),     32'd1);
    check("fill_cnt",   32'(wr_cnt),   32'd100);
    check("fill_rdy0",  32'(in_ready), 32'd0);
    rd(0,   32'h1000, "rd0");
    rd(50,  32'h1032, "rd50");
    rd(99,  32'h1063, "rd99");
    rd(100, 32'h0,    "rd100");
    rd(127, 32'h0,    "rd127");

    // Refill from DONE with valid toggling
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBAD0;
    #1;
    check("start_rdy0", 32'(in_ready), 32'd0);
    step();
    start = 1'b0;
    check("refill_done0", 32'(done),   32'd0);
    check("refill_cnt0",  32'(wr_cnt), 32'd0);
    exp_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = (k % 2 == 0) ? 32'h2000 + 32'(k / 2) : 32'hBAD1;
      step();
      if (k % 2 == 0) exp_cnt++;
      check("gap_cnt", 32'(wr_cnt), 32'(exp_cnt));
      check("gap_done", 32'(done), 32'(exp_cnt == 100));
    end
    in_valid = 1'b1;
    in_data  = 32'hFFFF;
    step();
    step();
    in_valid = 1'b0;
    check("hold_cnt",  32'(wr_cnt),   32'd100);
    check("hold_done", 32'(done),     32'd1);
    check("hold_rdy",  32'(in_ready), 32'd0);
    rd(0,  32'h2000, "gap_rd0");
    rd(99, 32'h2063, "gap_rd99");

    // Abort after 40 transfers
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h3000 + 32'(i);
      step();
    end
    check("pre_abort_cnt", 32'(wr_cnt), 32'd40);
    start   = 1'b1;
    in_data = 32'hAAAA;
    #1;
    check("abort_rdy0", 32'(in_ready), 32'd0);
    step();
    start = 1'b0;
    check("abort_cnt", 32'(wr_cnt), 32'd0);
    in_data = 32'h4000;
    step();
    in_valid = 1'b0;
    check("post_abort_cnt", 32'(wr_cnt), 32'd1);
    rd(0,  32'h4000, "abort_rd0");
    rd(1,  32'h3001, "abort_rd1");
    rd(39, 32'h3027, "abort_rd39");
    rd(40, 32'h2028, "abort_rd40");

    // Read-during-write at address 5
    for (int a = 1; a < 5; a++) begin
      in_valid = 1'b1;
      in_data  = 32'h5000 + 32'(a);
      step();
    end
    rd_addr  = 7'd5;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    check("rdw_old", rd_data, 32'h3005);
    step();
    check("rdw_new", rd_data, 32'hDEADBEEF);
    check("rdw_cnt", 32'(wr_cnt), 32'd6);

    // Reset mid-fill at 60 transfers
    for (int a = 6; a < 60; a++) begin
      in_valid = 1'b1;
      in_data  = 32'h6000 + 32'(a);
      step();
    end
    check("pre_rst_cnt", 32'(wr_cnt), 32'd60);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cnt",   32'(wr_cnt),   32'd0);
    check("mid_rst_done",  32'(done),     32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_rdata", rd_data,       32'd0);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_cnt",   32'(wr_cnt),   32'd0);
    rd(10, 32'h600A,     "post_rst_rd10");
    rd(5,  32'hDEADBEEF, "post_rst_rd5");
    rd(0,  32'h4000,     "post_rst_rd0");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
